// File: rtl/adder_arbiter.sv
// Round-robin front end for one shared registered adder: grants one requester at a time,
// presents its operands, and returns the tagged sum over a valid/ready response channel.
module adder_arbiter #(
  parameter int DATA_W = 64,
  parameter int N_REQ  = 4,
  parameter int ID_W   = 2
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic [N_REQ-1:0]        i_req_valid,
  output logic [N_REQ-1:0]        o_req_ready,
  input  logic [N_REQ*DATA_W-1:0] i_req_data1,
  input  logic [N_REQ*DATA_W-1:0] i_req_data2,
  output logic [DATA_W-1:0]       o_add_data1,
  output logic [DATA_W-1:0]       o_add_data2,
  input  logic [DATA_W-1:0]       i_add_data,
  output logic                    o_rsp_valid,
  output logic [ID_W-1:0]         o_rsp_id,
  output logic [DATA_W-1:0]       o_rsp_data,
  input  logic                    i_rsp_ready,
  output logic                    o_busy
);

  // state | meaning
  // IDLE  | no operation outstanding
  // BUSY  | operands issued, adder computing
  // RESP  | result held until the consumer takes it
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;

  state_e            state_q;
  logic [ID_W-1:0]   last_gnt_q;
  logic [ID_W-1:0]   id_q;
  logic [ID_W-1:0]   rsp_id_q;
  logic [DATA_W-1:0] rsp_data_q;
  logic              rsp_valid_q;

  logic              gnt_ok;
  logic              gnt_any;
  logic [ID_W-1:0]   gnt_id;
  logic [ID_W-1:0]   scan_idx;

  // Reset gates the grant so no requester sees ready while reset is held.
  always_comb begin
    gnt_any     = 1'b0;
    gnt_id      = '0;
    scan_idx    = '0;
    o_req_ready = '0;
    o_add_data1 = '0;
    o_add_data2 = '0;
    gnt_ok      = i_rst_n && ((state_q == IDLE) || (state_q == RESP && i_rsp_ready));
    for (int k = 1; k <= N_REQ; k++) begin
      scan_idx = ID_W'((int'(last_gnt_q) + k) % N_REQ);
      if (gnt_ok && !gnt_any && i_req_valid[scan_idx]) begin
        gnt_any               = 1'b1;
        gnt_id                = scan_idx;
        o_req_ready[scan_idx] = 1'b1;
        o_add_data1           = i_req_data1[scan_idx*DATA_W +: DATA_W];
        o_add_data2           = i_req_data2[scan_idx*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= IDLE;
      last_gnt_q  <= ID_W'(N_REQ - 1);
      id_q        <= '0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
      rsp_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (gnt_any) begin
            state_q    <= BUSY;
            id_q       <= gnt_id;
            last_gnt_q <= gnt_id;
          end
        end
        BUSY: begin
          state_q     <= RESP;
          rsp_data_q  <= i_add_data;
          rsp_id_q    <= id_q;
          rsp_valid_q <= 1'b1;
        end
        RESP: begin
          if (i_rsp_ready) begin
            rsp_valid_q <= 1'b0;
            if (gnt_any) begin
              state_q    <= BUSY;
              id_q       <= gnt_id;
              last_gnt_q <= gnt_id;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_rsp_valid = rsp_valid_q;
  assign o_rsp_id    = rsp_id_q;
  assign o_rsp_data  = rsp_data_q;
  assign o_busy      = (state_q != IDLE);

endmodule

// File: tb/tb_adder_arbiter.sv
// Bench for adder_arbiter: directed scenarios plus random traffic against a transaction-level
// model (round-robin pick rule, one outstanding operation, response two cycles after grant).
module tb_adder_arbiter;
  localparam int DW = 64;
  localparam int NR = 4;
  localparam int IW = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NR-1:0]     req_valid = '0;
  logic [NR-1:0]     req_ready;
  logic [NR*DW-1:0]  data1, data2;
  logic [DW-1:0]     add1, add2, add_q;
  logic              rsp_valid, rsp_ready = 1'b0, busy;
  logic [IW-1:0]     rsp_id;
  logic [DW-1:0]     rsp_data;
  logic [DW-1:0]     op1 [NR];
  logic [DW-1:0]     op2 [NR];

  int n_cmp = 0;
  int n_err = 0;

  // reference model state
  bit                inflight_m, rsp_valid_m;
  int                inf_id, rsp_id_m, last_m;
  logic [DW-1:0]     inf_data, rsp_data_m;
  int                gnt_log[$];

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < NR; i++) begin
      data1[i*DW +: DW] = op1[i];
      data2[i*DW +: DW] = op2[i];
    end
  end

  // shared adder: one-cycle registered, output reset to 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) add_q <= '0;
    else        add_q <= add1 + add2;
  end

  adder_arbiter #(.DATA_W(DW), .N_REQ(NR), .ID_W(IW)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req_valid(req_valid), .o_req_ready(req_ready),
    .i_req_data1(data1), .i_req_data2(data2),
    .o_add_data1(add1), .o_add_data2(add2), .i_add_data(add_q),
    .o_rsp_valid(rsp_valid), .o_rsp_id(rsp_id), .o_rsp_data(rsp_data),
    .i_rsp_ready(rsp_ready), .o_busy(busy)
  );

  task automatic chk(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] rand64();
    return {$urandom, $urandom};
  endfunction

  function automatic int pick(input logic [NR-1:0] v, input int last);
    for (int i = 1; i <= NR; i++) begin
      int idx;
      idx = (last + i) % NR;
      if (v[idx]) return idx;
    end
    return -1;
  endfunction

  // One clock cycle: starts and ends at a falling edge, inputs already applied.
  task automatic tick();
    int k;
    bit occ, can;
    logic [NR-1:0] er;
    logic [DW-1:0] e1, e2;
    occ = inflight_m || rsp_valid_m;
    can = !occ || (rsp_valid_m && rsp_ready);
    k   = can ? pick(req_valid, last_m) : -1;
    er = '0; e1 = '0; e2 = '0;
    if (k >= 0) begin
      er[k] = 1'b1; e1 = op1[k]; e2 = op2[k];
    end
    #1;
    chk("req_ready", DW'(req_ready), DW'(er));
    chk("add_data1", add1, e1);
    chk("add_data2", add2, e2);
    chk("busy", DW'(busy), DW'(occ));
    chk("rsp_valid", DW'(rsp_valid), DW'(rsp_valid_m));
    if (rsp_valid_m) begin
      chk("rsp_id", DW'(rsp_id), DW'(rsp_id_m));
      chk("rsp_data", rsp_data, rsp_data_m);
    end
    @(posedge clk);
    if (rsp_valid_m && rsp_ready) rsp_valid_m = 1'b0;
    if (inflight_m) begin
      rsp_valid_m = 1'b1; rsp_id_m = inf_id; rsp_data_m = inf_data; inflight_m = 1'b0;
    end
    if (k >= 0) begin
      inflight_m = 1'b1; inf_id = k; inf_data = e1 + e2; last_m = k;
      gnt_log.push_back(k);
    end
    #1;
    if (k >= 0) begin
      req_valid[k] = 1'b0; op1[k] = rand64(); op2[k] = rand64();
    end
    @(negedge clk);
  endtask

  // Asserted at a falling edge; checks outputs collapse immediately, even with requests pending.
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_req_ready", DW'(req_ready), '0);
    chk("rst_rsp_valid", DW'(rsp_valid), '0);
    chk("rst_rsp_id", DW'(rsp_id), '0);
    chk("rst_rsp_data", rsp_data, '0);
    chk("rst_busy", DW'(busy), '0);
    chk("rst_add_data1", add1, '0);
    inflight_m = 1'b0; rsp_valid_m = 1'b0; last_m = NR - 1;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < NR; i++) begin
      op1[i] = rand64(); op2[i] = rand64();
    end
    @(negedge clk);
    do_reset();

    // 1: single requester 2, 5 + 7
    op1[2] = 64'd5; op2[2] = 64'd7; req_valid = 4'b0100; rsp_ready = 1'b0;
    #1 chk("t1_ready", DW'(req_ready), 64'h4);
    tick(); tick();
    #1;
    chk("t1_rsp_valid", DW'(rsp_valid), 64'd1);
    chk("t1_rsp_id", DW'(rsp_id), 64'd2);
    chk("t1_rsp_data", rsp_data, 64'd12);
    rsp_ready = 1'b1;
    tick(); tick();

    // 2: all requesters valid every cycle after reset
    @(negedge clk);
    do_reset();
    gnt_log.delete();
    rsp_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      req_valid = 4'hF;
      tick();
    end
    if (gnt_log.size() >= 5) begin
      chk("t2_gnt0", DW'(gnt_log[0]), 64'd0);
      chk("t2_gnt1", DW'(gnt_log[1]), 64'd1);
      chk("t2_gnt2", DW'(gnt_log[2]), 64'd2);
      chk("t2_gnt3", DW'(gnt_log[3]), 64'd3);
      chk("t2_gnt4", DW'(gnt_log[4]), 64'd0);
    end else chk("t2_gnt_count", DW'(gnt_log.size()), 64'd5);
    req_valid = '0;
    tick(); tick(); tick();

    // 3: wrap-around sum from requester 1
    op1[1] = 64'hFFFF_FFFF_FFFF_FFFF; op2[1] = 64'd2; req_valid = 4'b0010; rsp_ready = 1'b0;
    tick(); tick();
    #1;
    chk("t3_rsp_id", DW'(rsp_id), 64'd1);
    chk("t3_rsp_data", rsp_data, 64'd1);

    // 4: backpressure with requester 3 waiting
    req_valid = 4'b1000;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("t4_hold_ready", DW'(req_ready), 64'd0);
      chk("t4_hold_data", rsp_data, 64'd1);
      tick();
    end
    rsp_ready = 1'b1;
    #1 chk("t4_release_ready", DW'(req_ready), 64'h8);
    tick();
    req_valid = '0;
    tick(); tick();

    // 5: fairness, requester 3 arrives while requester 0 is in flight
    gnt_log.delete();
    req_valid = 4'b0001;
    tick();
    req_valid = 4'b1001;
    tick(); tick();
    req_valid[0] = 1'b1;
    tick(); tick();
    if (gnt_log.size() >= 3) begin
      chk("t5_first", DW'(gnt_log[0]), 64'd0);
      chk("t5_second", DW'(gnt_log[1]), 64'd3);
      chk("t5_third", DW'(gnt_log[2]), 64'd0);
    end else chk("t5_gnt_count", DW'(gnt_log.size()), 64'd3);
    req_valid = '0;
    tick(); tick();

    // random traffic
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NR; i++)
        if (!req_valid[i] && ($urandom_range(0, 3) == 0)) req_valid[i] = 1'b1;
      rsp_ready = ($urandom_range(0, 9) < 7);
      tick();
    end

    // 6: reset while BUSY, then lowest valid index wins
    req_valid = '0; rsp_ready = 1'b1;
    tick(); tick(); tick();
    req_valid = 4'b0100;
    tick();
    #1 chk("t6_in_busy", DW'(busy), 64'd1);
    req_valid = 4'b1010;
    do_reset();
    gnt_log.delete();
    tick(); tick(); tick();
    if (gnt_log.size() >= 1) chk("t6_first_gnt", DW'(gnt_log[0]), 64'd1);
    else chk("t6_gnt_count", DW'(gnt_log.size()), 64'd1);
    req_valid = '0;
    for (int c = 0; c < 6; c++) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/adder_arbiter.md
Name: adder_arbiter

Overview:
- Round-robin arbiter that shares one registered 64-bit adder (one-cycle latency, output register reset to 0) among N_REQ requesters.
- Accepts operand pairs over a valid/ready handshake and drives them to the adder.
- Captures the adder result one cycle later and returns it, tagged with the requester ID, over a valid/ready response channel.
- Sits between execution sub-units (address calc, PC increment, etc.) and a single shared adder instance.

Parameters:
DATA_W, 64, operand/result width; must match the adder instance.
N_REQ, 4, number of requesters (2..8).
ID_W, 2, width of the requester ID; must be at least clog2(N_REQ).

Ports:
i_clk  in  1  clock; all state updates on its rising edge.
i_rst_n  in  1  reset; asynchronous and active-low.
i_req_valid  in  N_REQ  per-requester request valid.
o_req_ready  out  N_REQ  per-requester grant; at most one bit set per cycle.
i_req_data1  in  N_REQ*DATA_W  packed operand 1; requester k occupies bits [k*DATA_W +: DATA_W].
i_req_data2  in  N_REQ*DATA_W  packed operand 2, same packing.
o_add_data1  out  DATA_W  operand 1 to the adder.
o_add_data2  out  DATA_W  operand 2 to the adder.
i_add_data  in  DATA_W  adder result, valid one cycle after the operands are presented.
o_rsp_valid  out  1  response valid.
o_rsp_id  out  ID_W  ID of the requester that owns the response.
o_rsp_data  out  DATA_W  sum.
i_rsp_ready  in  1  response consumer ready.
o_busy  out  1  high whenever state is not IDLE.

Behaviour:
- States: IDLE, BUSY (adder computing), RESP (result held).
- Grant condition: state==IDLE, or state==RESP with i_rsp_ready=1.
  - When the condition holds and any i_req_valid is set, exactly one requester k is granted that cycle.
  - o_req_ready[k]=1, combinational in the same cycle.
  - o_add_data1/2 = requester k's operands.
  - The transfer completes at that edge.
- Operands when no grant: o_add_data1/2 = 0.
- Arbitration: round-robin.
  - Pointer last_gnt, reset value N_REQ-1, so requester 0 has top priority after reset.
  - Search order is last_gnt+1, last_gnt+2, … modulo N_REQ.
  - last_gnt updates to k on every grant.
  - A requester that is not valid is skipped without losing its turn order.
- Transitions:
  - IDLE -> BUSY on a grant; the granted ID is latched into id_r.
  - BUSY -> RESP unconditionally. At the BUSY edge, rsp_data_r <= i_add_data and o_rsp_valid becomes 1. Latency from grant edge to o_rsp_valid is 2 cycles.
  - RESP with i_rsp_ready=0: hold o_rsp_valid, o_rsp_id and o_rsp_data stable; no grant.
  - RESP with i_rsp_ready=1 and a grant: the response completes and the new request issues in the same cycle; go to BUSY. Sustained throughput is one operation per 2 cycles.
  - RESP with i_rsp_ready=1 and no valid request: go to IDLE; o_rsp_valid drops next cycle.
- Arithmetic: no interpretation; the sum wraps modulo 2^DATA_W, as produced by the adder.
- Requester rule: i_req_valid and operands stay stable until granted. The block samples operands only in the grant cycle.
- Reset, at any time including mid-operation:
  - State=IDLE, o_rsp_valid=0, o_rsp_id=0, o_rsp_data=0, last_gnt=N_REQ-1, o_busy=0.
  - o_req_ready=0 while reset is asserted.
  - In-flight operations are dropped and produce no response.
- o_rsp_id and o_rsp_data are registered outputs; o_req_ready and o_add_data* are combinational from state, pointer and requests.

Test Plan:
1. Reset, then requester 2 alone sends 5 + 7 -> o_req_ready=4'b0100 in that cycle; o_rsp_valid=1 two cycles later with id=2, data=12; o_busy high throughout.
2. All four valid every cycle, i_rsp_ready=1 -> grant order 0,1,2,3,0; one response every 2 cycles with matching IDs; no cycle with more than one ready bit set.
3. Wrap-around operands 0xFFFF_FFFF_FFFF_FFFF + 2 from requester 1 -> o_rsp_data=1, id=1.
4. Backpressure: response pending, i_rsp_ready held 0 for 5 cycles while requester 3 is valid -> response held stable, o_req_ready=0; on the cycle i_rsp_ready=1, requester 3 is granted in that same cycle.
5. Fairness: requester 0 valid continuously, requester 3 raises valid while requester 0's operation is in flight -> requester 3 is granted next, before requester 0 is granted again.
6. Assert i_rst_n=0 in BUSY -> all outputs zero immediately; after release, no stale response appears; the first grant goes to the lowest valid index.
